run_pattern_tx: RTL and testbench
=================================

# run_pattern_tx

Serial run-pattern transmitter that drives the single-bit stream consumed by the team's consecutive-ones sequence detector. Accepts frame requests (run length, gap length, repeat count) over a valid/ready handshake and emits repeated bursts of `1` bits, each followed by a gap of `0` bits. It also raises a reference strobe on the exact bit that should make a downstream five-ones detector fire, so detector benches can self-check. It sits on the stimulus/link side of the detector, clocked in the same domain.

## Interface
- `RUN_W`, 3: width of run-length field; max run = 2^RUN_W-1.
- `GAP_W`, 3: width of gap-length field.
- `REP_W`, 4: width of repeat-count field.
- `HIT_POS`, 5: 1-based position within a run of ones at which `expect_hit` asserts.

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  frame request valid.
- `req_ready`  out  1  block can accept a request (high only in IDLE).
- `req_run`  in  RUN_W  number of `1` bits per burst (0 allowed).
- `req_gap`  in  GAP_W  number of `0` bits after each burst (0 treated as 1).
- `req_reps`  in  REP_W  bursts per frame (0 treated as 1).
- `output_signal`  out  1  serial bit stream.
- `busy`  out  1  high while a frame is in progress (not IDLE).
- `expect_hit`  out  1  high in the cycle `output_signal` carries the HIT_POS-th consecutive 1.
- `frame_done`  out  1  one-cycle pulse during the final gap bit of a frame.

## Operation
- States: IDLE, ONES, GAP. All outputs are decoded from registered state/counters; there are no combinational paths from request inputs to outputs.
- IDLE:
  - `output_signal`=0 and `req_ready`=1.
  - On `req_valid && req_ready`, latch `run`, `gap_eff = (req_gap==0)?1:req_gap`, and `reps_eff = (req_reps==0)?1:req_reps`.
  - Go to ONES if `run`≠0, else GAP.
  - Clear the bit counter. Load the repeat counter with `reps_eff`.
- ONES:
  - `output_signal`=1; the bit counter counts 1..run.
  - After `run` cycles, go to GAP.
- GAP:
  - `output_signal`=0 for `gap_eff` cycles.
  - On the last gap cycle, decrement the repeat counter. If any repeats remain, go to ONES (or GAP again if run=0); otherwise go to IDLE.
- `expect_hit` = (state==ONES) && (bit position==HIT_POS). It never asserts when run<HIT_POS.
  - The gap is always at least 1, so consecutive-ones history resets between bursts and at most one hit occurs per burst.
- `frame_done` = (state==GAP) && last gap bit && last repeat.
- Requests are ignored when `req_ready`=0. Inputs are sampled only in the handshake cycle; later changes on `req_*` have no effect on the frame in progress.
- Counter widths: bit counter max(RUN_W,GAP_W) bits; repeat counter REP_W bits. Counters never wrap within a frame.

## Timing
- Reset (asynchronous assert, any time, including mid-frame) forces:
  - state IDLE;
  - all counters 0;
  - `output_signal`=0, `busy`=0, `expect_hit`=0, `frame_done`=0, `req_ready`=1.
  
  The frame in progress is discarded.
- Handshake at edge T: the first frame bit appears on `output_signal` in cycle T+1, and `busy`=1 from T+1.
- Frame length in cycles = `reps_eff*(run+gap_eff)`.
- `frame_done` is high in the last frame cycle. The next cycle is IDLE (`busy`=0, `req_ready`=1, `output_signal`=0).
- Back-to-back frames: the minimum spacing is one IDLE cycle, during which `output_signal`=0.
- `expect_hit` is coincident with its bit, so a detector registering that bit is in its match state one cycle later.

## Test plan
- **Reset values:** assert `rst_n`=0 mid-cycle → all outputs reach their reset values immediately; after release, `req_ready`=1 and `output_signal`=0.
- **Basic frame:** run=5, gap=2, reps=1 accepted at T → `output_signal` over T+1..T+7 = 1,1,1,1,1,0,0; `expect_hit` only at T+5; `frame_done` only at T+7; `req_ready`=1 at T+8.
- **Multiple repeats:** run=7, gap=0, reps=2 → `output_signal` = 1111111 0 1111111 0 (16 cycles); `expect_hit` at cycles 5 and 13; `frame_done` at cycle 16.
- **Degenerate fields:** run=0, gap=3, reps=0 → three 0 bits, `busy`=1 for 3 cycles, `expect_hit` never, `frame_done` on the 3rd cycle. Run=4 → `expect_hit` never asserts.
- **Busy handshake:** hold `req_valid`=1 with changing fields throughout a frame → only the first request is accepted, the running frame is unaffected, and the next request is accepted in the IDLE cycle after `frame_done`.
- **Reset mid-frame:** assert `rst_n`=0 during ONES of run=7 → `output_signal` drops to 0 asynchronously; after release, a new request with run=2, gap=1, reps=1 produces 1,1,0 with no residue from the aborted frame.

Source files
------------

// File: rtl/run_pattern_tx.sv
// Serial run-pattern transmitter: repeated bursts of ones separated by zero gaps,
// with a reference strobe on the bit that should trigger a consecutive-ones detector.
module run_pattern_tx #(
    parameter int RUN_W   = 3,
    parameter int GAP_W   = 3,
    parameter int REP_W   = 4,
    parameter int HIT_POS = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [RUN_W-1:0] req_run,
    input  logic [GAP_W-1:0] req_gap,
    input  logic [REP_W-1:0] req_reps,
    output logic             output_signal,
    output logic             busy,
    output logic             expect_hit,
    output logic             frame_done
);

    localparam int CW = (RUN_W > GAP_W) ? RUN_W : GAP_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ONES = 2'd1,
        GAP  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [REP_W-1:0] rep_q, rep_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [GAP_W-1:0] gap_q, gap_d;

    logic [CW:0] pos;
    logic        last_one;
    logic        last_gap;
    logic        last_rep;

    // 1-based position of the current bit within its burst or gap
    assign pos      = {1'b0, cnt_q} + (CW+1)'(1);
    assign last_one = (pos == (CW+1)'(run_q));
    assign last_gap = (pos == (CW+1)'(gap_q));
    assign last_rep = (rep_q == REP_W'(1));

    assign req_ready     = (state_q == IDLE);
    assign busy          = (state_q != IDLE);
    assign output_signal = (state_q == ONES);
    assign expect_hit    = (state_q == ONES) && (pos == (CW+1)'(HIT_POS));
    assign frame_done    = (state_q == GAP) && last_gap && last_rep;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rep_d   = rep_q;
        run_d   = run_q;
        gap_d   = gap_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    run_d   = req_run;
                    gap_d   = (req_gap == '0) ? GAP_W'(1) : req_gap;
                    rep_d   = (req_reps == '0) ? REP_W'(1) : req_reps;
                    cnt_d   = '0;
                    state_d = (req_run != '0) ? ONES : GAP;
                end
            end
            ONES: begin
                if (last_one) begin
                    cnt_d   = '0;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            GAP: begin
                if (last_gap) begin
                    cnt_d = '0;
                    rep_d = rep_q - REP_W'(1);
                    if (last_rep) begin
                        state_d = IDLE;
                    end else begin
                        state_d = (run_q != '0) ? ONES : GAP;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rep_q   <= '0;
            run_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rep_q   <= rep_d;
            run_q   <= run_d;
            gap_q   <= gap_d;
        end
    end

endmodule

// File: tb/tb_run_pattern_tx.sv
// Directed self-checking bench for run_pattern_tx.
module tb_run_pattern_tx;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_run;
    logic [2:0] req_gap;
    logic [3:0] req_reps;
    logic       output_signal;
    logic       busy;
    logic       expect_hit;
    logic       frame_done;

    int tests = 0;
    int fails = 0;

    run_pattern_tx dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_run      (req_run),
        .req_gap      (req_gap),
        .req_reps     (req_reps),
        .output_signal(output_signal),
        .busy         (busy),
        .expect_hit   (expect_hit),
        .frame_done   (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic send_req(input logic [2:0] r, input logic [2:0] g,
                            input logic [3:0] n);
        @(negedge clk);
        req_run   = r;
        req_gap   = g;
        req_reps  = n;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #13;
        tests++;
        if ({req_ready, output_signal, busy, expect_hit, frame_done} !== 5'b10000) begin
            fails++;
            $display("FAIL reset_hold: got %b want 10000",
                     {req_ready, output_signal, busy, expect_hit, frame_done});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if ({req_ready, output_signal, busy, expect_hit, frame_done} !== 5'b10000) begin
            fails++;
            $display("FAIL reset_release: got %b want 10000",
                     {req_ready, output_signal, busy, expect_hit, frame_done});
        end
    endtask

    task automatic test_basic();
        logic [6:0] eo = 7'b1111100;
        logic [6:0] eh = 7'b0000100;
        logic [6:0] ed = 7'b0000001;
        send_req(3'd5, 3'd2, 4'd1);
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            tests++;
            if ({output_signal, expect_hit, frame_done, busy} !==
                {eo[7-i], eh[7-i], ed[7-i], 1'b1}) begin
                fails++;
                $display("FAIL basic_c%0d: got o/h/d/b=%b want %b", i,
                         {output_signal, expect_hit, frame_done, busy},
                         {eo[7-i], eh[7-i], ed[7-i], 1'b1});
            end
        end
        @(negedge clk);
        tests++;
        if ({req_ready, busy, output_signal} !== 3'b100) begin
            fails++;
            $display("FAIL basic_idle: got r/b/o=%b want 100",
                     {req_ready, busy, output_signal});
        end
    endtask

    task automatic test_repeats();
        logic [15:0] eo = 16'b1111111011111110;
        logic [15:0] eh = 16'b0000100000001000;
        logic [15:0] ed = 16'b0000000000000001;
        send_req(3'd7, 3'd0, 4'd2);
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            tests++;
            if ({output_signal, expect_hit, frame_done, busy} !==
                {eo[16-i], eh[16-i], ed[16-i], 1'b1}) begin
                fails++;
                $display("FAIL repeats_c%0d: got o/h/d/b=%b want %b", i,
                         {output_signal, expect_hit, frame_done, busy},
                         {eo[16-i], eh[16-i], ed[16-i], 1'b1});
            end
        end
        @(negedge clk);
        tests++;
        if ({req_ready, busy, output_signal} !== 3'b100) begin
            fails++;
            $display("FAIL repeats_idle: got r/b/o=%b want 100",
                     {req_ready, busy, output_signal});
        end
    endtask

    task automatic test_degenerate();
        logic [2:0] ed = 3'b001;
        logic [4:0] eo = 5'b11110;
        send_req(3'd0, 3'd3, 4'd0);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            tests++;
            if ({output_signal, expect_hit, frame_done, busy} !==
                {1'b0, 1'b0, ed[3-i], 1'b1}) begin
                fails++;
                $display("FAIL degen0_c%0d: got o/h/d/b=%b want %b", i,
                         {output_signal, expect_hit, frame_done, busy},
                         {1'b0, 1'b0, ed[3-i], 1'b1});
            end
        end
        @(negedge clk);
        tests++;
        if ({req_ready, busy} !== 2'b10) begin
            fails++;
            $display("FAIL degen0_idle: got r/b=%b want 10", {req_ready, busy});
        end
        send_req(3'd4, 3'd1, 4'd1);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            tests++;
            if ({output_signal, expect_hit, frame_done} !==
                {eo[5-i], 1'b0, (i == 5)}) begin
                fails++;
                $display("FAIL run4_c%0d: got o/h/d=%b want %b", i,
                         {output_signal, expect_hit, frame_done},
                         {eo[5-i], 1'b0, (i == 5)});
            end
        end
    endtask

    task automatic test_busy_handshake();
        logic [3:0] eo = 4'b1110;
        logic [2:0] e2 = 3'b110;
        @(negedge clk);
        req_run   = 3'd3;
        req_gap   = 3'd1;
        req_reps  = 4'd1;
        req_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            tests++;
            if ({output_signal, frame_done, req_ready} !== {eo[4-i], (i == 4), 1'b0}) begin
                fails++;
                $display("FAIL busy_c%0d: got o/d/r=%b want %b", i,
                         {output_signal, frame_done, req_ready},
                         {eo[4-i], (i == 4), 1'b0});
            end
            req_run  = 3'(7 - i);
            req_gap  = 3'(i + 2);
            req_reps = 4'(15 - i);
        end
        @(negedge clk);
        tests++;
        if ({req_ready, output_signal} !== 2'b10) begin
            fails++;
            $display("FAIL busy_idle: got r/o=%b want 10", {req_ready, output_signal});
        end
        req_run  = 3'd2;
        req_gap  = 3'd1;
        req_reps = 4'd1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            tests++;
            if ({output_signal, frame_done} !== {e2[3-i], (i == 3)}) begin
                fails++;
                $display("FAIL busy_next_c%0d: got o/d=%b want %b", i,
                         {output_signal, frame_done}, {e2[3-i], (i == 3)});
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midframe();
        logic [2:0] e2 = 3'b110;
        send_req(3'd7, 3'd1, 4'd1);
        repeat (3) @(negedge clk);
        tests++;
        if (output_signal !== 1'b1) begin
            fails++;
            $display("FAIL midrst_pre: got o=%b want 1", output_signal);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({req_ready, output_signal, busy, expect_hit, frame_done} !== 5'b10000) begin
            fails++;
            $display("FAIL midrst_async: got %b want 10000",
                     {req_ready, output_signal, busy, expect_hit, frame_done});
        end
        @(negedge clk);
        rst_n = 1'b1;
        send_req(3'd2, 3'd1, 4'd1);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            tests++;
            if ({output_signal, expect_hit, frame_done} !== {e2[3-i], 1'b0, (i == 3)}) begin
                fails++;
                $display("FAIL midrst_new_c%0d: got o/h/d=%b want %b", i,
                         {output_signal, expect_hit, frame_done},
                         {e2[3-i], 1'b0, (i == 3)});
            end
        end
        @(negedge clk);
        tests++;
        if ({req_ready, busy, output_signal} !== 3'b100) begin
            fails++;
            $display("FAIL midrst_idle: got r/b/o=%b want 100",
                     {req_ready, busy, output_signal});
        end
    endtask

    initial begin
        req_valid = 1'b0;
        req_run   = '0;
        req_gap   = '0;
        req_reps  = '0;
        rst_n     = 1'b1;
        #2;
        test_reset();
        test_basic();
        test_repeats();
        test_degenerate();
        test_busy_handshake();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
